// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int DATA_BITS = 8;

  function automatic int baud_w(input int cpb);
    return (cpb < 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick on the last cycle of each bit time.
module uart_baud_cnt
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = baud_w(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FWFT FIFO and sends each as a UART frame on txd.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic        rclk,
  input  logic        rrst_n,
  input  logic        enable,
  input  logic        empty,
  input  logic [7:0]  readData,
  output logic        rinc,
  output logic        txd,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] tx_count
);

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        tick;
  logic        idle;

  assign idle = (state_q == IDLE);

  // Gated by reset so a held reset can never pop the FIFO.
  assign rinc = rrst_n & idle & enable & ~empty;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (rclk),
    .rst_n(rrst_n),
    .clr  (idle),
    .en   (~idle),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    unique case (state_q)
      IDLE: begin
        if (rinc) begin
          shift_d = readData;
          par_d   = ^readData;
          cnt_d   = cnt_q + 16'd1;
          bit_d   = '0;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          txd_d   = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            txd_d   = PARITY_EN ? par_q : 1'b1;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      cnt_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign tx_count   = cnt_q;
  assign frame_done = (state_q == STOP) & tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: frame vectors plus back-to-back, enable and reset sequences.
module tb_fifo_uart_tx;

  typedef struct {
    logic        par;
    logic [7:0]  data;
    logic [10:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, emp0, en1, emp1;
  logic [7:0]  rd0, rd1;
  logic        rinc0, txd0, busy0, fd0;
  logic        rinc1, txd1, busy1, fd1;
  logic [15:0] tc0, tc1;

  int checks = 0;
  int failures = 0;
  logic lg [0:199];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
    .rclk(clk), .rrst_n(rst_n), .enable(en0), .empty(emp0),
    .readData(rd0), .rinc(rinc0), .txd(txd0), .busy(busy0),
    .frame_done(fd0), .tx_count(tc0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
    .rclk(clk), .rrst_n(rst_n), .enable(en1), .empty(emp1),
    .readData(rd1), .rinc(rinc1), .txd(txd1), .busy(busy1),
    .frame_done(fd1), .tx_count(tc1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] decode(input int p);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = lg[p + 6 + 4*i];
    return b;
  endfunction

  task automatic run_vec(input vec_t v);
    int len, bad, fd_at, fd_n, rb;
    logic [15:0] c0;
    logic t;
    len = v.par ? 44 : 40;
    bad = 0; fd_at = -1; fd_n = 0; rb = 0;
    @(negedge clk);
    c0 = v.par ? tc1 : tc0;
    if (v.par) begin rd1 = v.data; emp1 = 1'b0; end
    else begin rd0 = v.data; emp0 = 1'b0; end
    #1 chk("pop_rinc", 32'(v.par ? rinc1 : rinc0), 32'd1);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1) begin emp0 = 1'b1; emp1 = 1'b1; end
      #1;
      t = v.par ? txd1 : txd0;
      if (t !== v.exp[(c-1)/4]) bad++;
      if (c % 4 == 2) chk("txd_bit", 32'(t), 32'(v.exp[(c-1)/4]));
      if (v.par ? fd1 : fd0) begin fd_n++; fd_at = c; end
      if ((v.par ? rinc1 : rinc0) || !(v.par ? busy1 : busy0)) rb++;
    end
    chk("txd_glitches", 32'(bad), 32'd0);
    chk("frame_done_n", 32'(fd_n), 32'd1);
    chk("frame_done_at", 32'(fd_at), 32'(len));
    chk("rinc_or_idle_in_frame", 32'(rb), 32'd0);
    @(negedge clk);
    #1;
    chk("busy_after", 32'(v.par ? busy1 : busy0), 32'd0);
    chk("txd_after", 32'(v.par ? txd1 : txd0), 32'd1);
    chk("tx_count_inc", 32'(v.par ? tc1 : tc0), 32'(c0 + 16'd1));
  endtask

  initial begin
    vec_t vecs[5];
    int pops[4];
    int np, bad, fdc;
    logic [7:0] bb[3];
    logic [7:0] eb[2];

    vecs[0] = '{par: 1'b0, data: 8'hA5, exp: 11'b11101001010};
    vecs[1] = '{par: 1'b0, data: 8'h00, exp: 11'b11000000000};
    vecs[2] = '{par: 1'b1, data: 8'h07, exp: 11'b11000001110};
    vecs[3] = '{par: 1'b1, data: 8'h03, exp: 11'b10000000110};
    vecs[4] = '{par: 1'b1, data: 8'hFF, exp: 11'b10111111110};
    bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33;
    eb[0] = 8'h5A; eb[1] = 8'h3C;

    rst_n = 1'b0;
    en0 = 1'b1; en1 = 1'b1; emp0 = 1'b1; emp1 = 1'b1;
    rd0 = 8'h00; rd1 = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_fd", 32'(fd0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (rinc0 || busy0 || !txd0 || rinc1 || busy1 || !txd1) bad++;
    end
    chk("idle_after_rst", 32'(bad), 32'd0);
    chk("rst_tx_count", 32'(tc0), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back from a 3-entry FIFO, starting from a fresh count.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    np = 0; bad = 0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      emp0 = (np >= 3);
      rd0 = (np < 3) ? bb[np] : 8'h00;
      #1;
      lg[c] = txd0;
      if (rinc0 && busy0) bad++;
      if (rinc0) begin
        if (np < 4) pops[np] = c;
        np++;
      end
    end
    emp0 = 1'b1;
    chk("b2b_pops", 32'(np), 32'd3);
    chk("b2b_gap1", 32'(pops[1] - pops[0]), 32'd41);
    chk("b2b_gap2", 32'(pops[2] - pops[1]), 32'd41);
    chk("b2b_byte0", 32'(decode(pops[0])), 32'h11);
    chk("b2b_byte1", 32'(decode(pops[1])), 32'h22);
    chk("b2b_byte2", 32'(decode(pops[2])), 32'h33);
    chk("b2b_start", 32'(lg[pops[1] + 2]), 32'd0);
    chk("b2b_stop", 32'(lg[pops[1] + 38]), 32'd1);
    chk("b2b_rinc_busy", 32'(bad), 32'd0);
    chk("b2b_tx_count", 32'(tc0), 32'd3);

    // Enable drops mid-frame, returns well after the frame ends.
    np = 0; fdc = -1;
    pops[0] = 1000;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == pops[0] + 10) en0 = 1'b0;
      if (c == 70) en0 = 1'b1;
      emp0 = (np >= 2);
      rd0 = (np < 2) ? eb[np] : 8'h00;
      #1;
      lg[c] = txd0;
      if (fd0 && fdc < 0) fdc = c;
      if (rinc0) begin
        if (np < 4) pops[np] = c;
        np++;
      end
    end
    emp0 = 1'b1;
    bad = 0;
    for (int c = 41; c < 71; c++) if (lg[c] !== 1'b1) bad++;
    chk("en_pops", 32'(np), 32'd2);
    chk("en_pop0", 32'(pops[0]), 32'd0);
    chk("en_pop1", 32'(pops[1]), 32'd70);
    chk("en_byte0", 32'(decode(0)), 32'h5A);
    chk("en_frame_done", 32'(fdc), 32'd40);
    chk("en_idle_high", 32'(bad), 32'd0);
    chk("en_next_start", 32'(lg[71]), 32'd0);
    chk("en_byte1", 32'(decode(70)), 32'h3C);

    // Reset lands asynchronously in the middle of the data bits.
    @(negedge clk);
    emp0 = 1'b0; rd0 = 8'h99;
    #1 chk("mr_pop", 32'(rinc0), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) emp0 = 1'b1;
    end
    #1 chk("mr_busy_pre", 32'(busy0), 32'd1);
    #1;
    rst_n = 1'b0; emp0 = 1'b0; rd0 = 8'h77;
    #1;
    chk("mr_txd", 32'(txd0), 32'd1);
    chk("mr_busy", 32'(busy0), 32'd0);
    chk("mr_tx_count", 32'(tc0), 32'd0);
    chk("mr_rinc", 32'(rinc0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mr_pop_after", 32'(rinc0), 32'd1);
    @(negedge clk);
    emp0 = 1'b1;
    #1;
    chk("mr_count1", 32'(tc0), 32'd1);
    chk("mr_busy1", 32'(busy0), 32'd1);
    chk("mr_start", 32'(txd0), 32'd0);
    repeat (45) @(negedge clk);
    #1 chk("mr_done_idle", 32'(busy0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
